// File: rtl/divider_iter_if.sv
// Handshake bundle between the core's DIV/MOD path and the iterative divider.
// The core (master) raises run and drives the operands. The divider (slave)
// returns stall and the registered quotient/remainder.
interface divider_iter_if;
   logic        run;
   logic        u;
   logic [31:0] x;
   logic [31:0] y;
   logic        stall;
   logic [31:0] quot;
   logic [31:0] rem;

   modport master (output run, u, x, y, input stall, quot, rem);
   modport slave  (input run, u, x, y, output stall, quot, rem);
endinterface

// File: rtl/divider_iter.sv
// Iterative 32-bit divider: one restoring step per cycle on operand
// magnitudes, followed by a single fix-up cycle. Signed results follow the
// Euclidean convention, so the remainder is never negative.
// Division by zero yields quot = all ones and rem = dividend.
module divider_iter (
   input  logic           clk,
   input  logic           rst,
   divider_iter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  cnt_reg;
   logic        sx_reg, sy_reg, zy_reg;
   logic [31:0] x_reg;       // dividend as captured, returned on divide-by-zero
   logic [31:0] dvd_reg;     // |x| shifts out MSB-first; quotient bits shift in
   logic [31:0] dvs_reg;     // |y|
   logic [31:0] prem_reg;    // partial remainder; always < |y|, so 32 bits suffice
   logic [31:0] quot_reg, rem_reg;

   logic        sx_in, sy_in;
   logic [31:0] ax_in, ay_in;
   logic [32:0] shifted, trial;
   logic        trial_ok;
   logic [31:0] q0, r0, q1;
   logic [31:0] fix_quot, fix_rem;

   // Operand signs and magnitudes at capture. -2^31 negates to itself, which
   // is the correct unsigned magnitude 0x80000000.
   always_comb begin
      sx_in = bus.x[31] & ~bus.u;
      sy_in = bus.y[31] & ~bus.u;
      ax_in = sx_in ? (32'd0 - bus.x) : bus.x;
      ay_in = sy_in ? (32'd0 - bus.y) : bus.y;
   end

   // One restoring step. The shifted remainder is 33 bits wide, and bit 32 of
   // the difference marks a negative trial.
   always_comb begin
      shifted  = {prem_reg, dvd_reg[31]};
      trial    = shifted - {1'b0, dvs_reg};
      trial_ok = ~trial[32];
   end

   // Sign fix-up from the magnitude quotient/remainder, all modulo 2^32.
   always_comb begin
      q0       = dvd_reg;
      r0       = prem_reg;
      q1       = q0 + 32'd1;
      fix_quot = q0;
      fix_rem  = r0;
      if (zy_reg) begin
         fix_quot = 32'hFFFF_FFFF;
         fix_rem  = x_reg;
      end else if (!sx_reg) begin
         fix_rem  = r0;
         fix_quot = sy_reg ? (32'd0 - q0) : q0;
      end else if (r0 == 32'd0) begin
         fix_rem  = 32'd0;
         fix_quot = sy_reg ? q0 : (32'd0 - q0);
      end else begin
         fix_rem  = dvs_reg - r0;
         fix_quot = sy_reg ? q1 : (32'd0 - q1);
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic. Dropping run anywhere before DONE abandons the operation.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (bus.run) state_next = CALC;
         CALC: begin
            if (!bus.run)               state_next = IDLE;
            else if (cnt_reg == 5'd31)  state_next = FIX;
         end
         FIX:  state_next = bus.run ? DONE : IDLE;
         DONE: if (!bus.run) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath. The outputs are written only by a completed FIX, so an aborted
   // operation leaves the previous result visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg  <= 5'd0;
         sx_reg   <= 1'b0;
         sy_reg   <= 1'b0;
         zy_reg   <= 1'b0;
         x_reg    <= 32'd0;
         dvd_reg  <= 32'd0;
         dvs_reg  <= 32'd0;
         prem_reg <= 32'd0;
         quot_reg <= 32'd0;
         rem_reg  <= 32'd0;
      end else begin
         case (state_reg)
            IDLE: if (bus.run) begin
               sx_reg   <= sx_in;
               sy_reg   <= sy_in;
               zy_reg   <= (bus.y == 32'd0);
               x_reg    <= bus.x;
               dvd_reg  <= ax_in;
               dvs_reg  <= ay_in;
               prem_reg <= 32'd0;
               cnt_reg  <= 5'd0;
            end
            CALC: if (bus.run) begin
               prem_reg <= trial_ok ? trial[31:0] : shifted[31:0];
               dvd_reg  <= {dvd_reg[30:0], trial_ok};
               cnt_reg  <= cnt_reg + 5'd1;
            end
            FIX: if (bus.run) begin
               quot_reg <= fix_quot;
               rem_reg  <= fix_rem;
            end
            default: ;
         endcase
      end
   end

   assign bus.stall = bus.run & (state_reg != DONE);
   assign bus.quot  = quot_reg;
   assign bus.rem   = rem_reg;

endmodule

// File: tb/tb_divider_iter.sv
// Bench for divider_iter. It applies a table of hand-computed vectors,
// hand-written abort/reset/handshake sequences and randomized operations
// checked against an arithmetic reference model.
module tb_divider_iter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   divider_iter_if bus ();

   divider_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      string       name;
      logic        u;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] eq;
      logic [31:0] er;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed results moved to the
   // Euclidean convention with a non-negative remainder.
   function automatic void ref_div(input logic uu, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      longint sa, sb, lq, lr;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
         return;
      end
      if (uu) begin
         q = a / b;
         r = a % b;
         return;
      end
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa - lq * sb;
      if (lr < 0) begin
         if (sb > 0) begin lq = lq - 1; lr = lr + sb; end
         else        begin lq = lq + 1; lr = lr - sb; end
      end
      q = lq[31:0];
      r = lr[31:0];
   endfunction

   // Raise run with operands and count the cycles during which stall is seen
   // high. The count is bounded so that a stuck divider cannot hang the run.
   task automatic do_op(input logic uu, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output int cyc);
      @(negedge clk);
      bus.run = 1'b1;
      bus.u   = uu;
      bus.x   = a;
      bus.y   = b;
      cyc     = 0;
      #1;
      while (bus.stall && cyc < 100) begin
         cyc++;
         @(negedge clk);
         if (scramble) begin
            bus.x = $urandom;
            bus.y = $urandom;
            bus.u = 1'($urandom);
         end
         #1;
      end
   endtask

   task automatic release_run();
      @(negedge clk);
      bus.run = 1'b0;
   endtask

   task automatic run_check(input string name, input logic uu, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eq,
                            input logic [31:0] er, input bit scramble);
      int cyc;
      do_op(uu, a, b, scramble, cyc);
      $display("%s: u=%0d x=%h y=%h -> quot=%h rem=%h stall_cycles=%0d",
               name, uu, a, b, bus.quot, bus.rem, cyc);
      chk({name, " latency"}, 32'(cyc), 32'd34);
      chk({name, " quot"}, bus.quot, eq);
      chk({name, " rem"}, bus.rem, er);
      release_run();
   endtask

   initial begin
      logic [31:0] eq, er, a, b, prev_q, prev_r;
      logic        uu;
      int          cyc;

      #5_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] eq, er, a, b, prev_q, prev_r;
      logic        uu;
      int          cyc;

      vecs[0]  = '{"unsigned 100/7",      1'b1, 32'd100,       32'd7,         32'd14,        32'd2};
      vecs[1]  = '{"unsigned max/1",      1'b1, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0};
      vecs[2]  = '{"signed -7/2",         1'b0, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFC,  32'd1};
      vecs[3]  = '{"signed -7/-2",        1'b0, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd4,         32'd1};
      vecs[4]  = '{"signed 7/-2",         1'b0, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1};
      vecs[5]  = '{"signed -6/3",         1'b0, 32'hFFFFFFFA,  32'd3,         32'hFFFFFFFE,  32'd0};
      vecs[6]  = '{"signed min/-1",       1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
      vecs[7]  = '{"signed min/1",        1'b0, 32'h80000000,  32'd1,         32'h80000000,  32'd0};
      vecs[8]  = '{"unsigned min/max",    1'b1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000};
      vecs[9]  = '{"div0 unsigned",       1'b1, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678};
      vecs[10] = '{"div0 signed",         1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678};
      vecs[11] = '{"signed 7/2",          1'b0, 32'd7,         32'd2,         32'd3,         32'd1};

      // Reset state, including stall following run while reset is held.
      rst     = 1'b1;
      bus.run = 1'b0;
      bus.u   = 1'b0;
      bus.x   = 32'd0;
      bus.y   = 32'd0;
      @(negedge clk);
      #1;
      chk("reset stall", 32'(bus.stall), 32'd0);
      chk("reset quot", bus.quot, 32'd0);
      chk("reset rem", bus.rem, 32'd0);
      bus.run = 1'b1;
      #1;
      chk("reset stall follows run", 32'(bus.stall), 32'd1);
      bus.run = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i])
         run_check(vecs[i].name, vecs[i].u, vecs[i].x, vecs[i].y, vecs[i].eq, vecs[i].er, 1'b0);
      prev_q = vecs[11].eq;
      prev_r = vecs[11].er;

      // Abort at CALC step 10. The state returns to IDLE and the outputs keep the prior result.
      @(negedge clk);
      bus.run = 1'b1; bus.u = 1'b1; bus.x = 32'd1000; bus.y = 32'd3;
      repeat (11) @(negedge clk);
      bus.run = 1'b0;
      #1;
      chk("abort stall", 32'(bus.stall), 32'd0);
      @(negedge clk);
      #1;
      chk("abort quot held", bus.quot, prev_q);
      chk("abort rem held", bus.rem, prev_r);
      $display("abort: quot=%h rem=%h", bus.quot, bus.rem);
      run_check("after abort 9/4", 1'b1, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

      // Reset asserted mid-CALC clears the outputs immediately.
      @(negedge clk);
      bus.run = 1'b1; bus.u = 1'b1; bus.x = 32'd500; bus.y = 32'd7;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midcalc reset quot", bus.quot, 32'd0);
      chk("midcalc reset rem", bus.rem, 32'd0);
      $display("reset mid-CALC: quot=%h rem=%h", bus.quot, bus.rem);
      bus.run = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_check("after reset 100/7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

      // Operands change every cycle after capture, so only the captured values count.
      run_check("scrambled -7/2", 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFC, 32'd1, 1'b1);

      // Holding run high in DONE keeps stall low and does not restart the divider.
      do_op(1'b1, 32'd1234567, 32'd89, 1'b0, cyc);
      chk("hold latency", 32'(cyc), 32'd34);
      bus.x = 32'd5; bus.y = 32'd1;
      repeat (5) begin
         @(negedge clk);
         #1;
         chk("hold stall", 32'(bus.stall), 32'd0);
         chk("hold quot", bus.quot, 32'd13871);
         chk("hold rem", bus.rem, 32'd48);
      end
      $display("hold in DONE: quot=%h rem=%h", bus.quot, bus.rem);
      release_run();
      run_check("reassert 40/6", 1'b1, 32'd40, 32'd6, 32'd6, 32'd4, 1'b0);

      // Randomized operations against the reference model.
      for (int i = 0; i < 150; i++) begin
         uu = 1'($urandom);
         a  = $urandom;
         case ($urandom_range(0, 4))
            0: b = $urandom;
            1: b = 32'($urandom_range(1, 20));
            2: b = 32'd0 - 32'($urandom_range(1, 20));
            3: b = (i % 2 == 0) ? 32'd0 : 32'hFFFFFFFF;
            default: begin
               b = $urandom;
               a = (i % 3 == 0) ? 32'h80000000 : {1'b1, 31'($urandom)};
            end
         endcase
         ref_div(uu, a, b, eq, er);
         run_check($sformatf("rand%0d", i), uu, a, b, eq, er, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
